// File: rtl/aes_dec_key_sched.sv
// AES-128 decryption key schedule: forward-expands the cipher key to round 10, then walks
// the schedule backwards to stream round keys 10..0 over a valid/ready handshake.

module aes_dec_key_sched #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [0:127] key_in,
    output logic         busy,
    output logic [0:127] kout,
    output logic [3:0]   kout_round,
    output logic         kout_valid,
    input  logic         kout_ready,
    output logic         done
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StFwd  = 2'd1;
    localparam logic [1:0] StEmit = 2'd2;

    localparam logic [3:0] LastRound = NR[3:0];

    logic [1:0]   state_q, state_d;
    logic [0:127] key_q, key_d;
    logic [3:0]   round_q, round_d;
    logic [7:0]   rc_q, rc_d;
    logic         busy_q, busy_d;
    logic         valid_q, valid_d;
    logic         done_q, done_d;

    logic [31:0]  k0, k1, k2, k3;
    logic [31:0]  sbox_in, rot, sub, t;
    logic [0:127] fwd_key, bwd_key;
    logic [7:0]   rc_fwd, rc_bwd;

    always_comb begin
        k0 = key_q[0:31];
        k1 = key_q[32:63];
        k2 = key_q[64:95];
        k3 = key_q[96:127];
        // Backward step needs the old w3, which is recovered as k3^k2.
        sbox_in = (state_q == StEmit) ? (k3 ^ k2) : k3;
        rot     = {sbox_in[23:0], sbox_in[31:24]};
    end

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .in_i  (rot[8*g +: 8]),
            .out_o (sub[8*g +: 8])
        );
    end

    always_comb begin
        t       = sub ^ {rc_q, 24'h000000};
        fwd_key = {k0 ^ t, k1 ^ k0 ^ t, k2 ^ k1 ^ k0 ^ t, k3 ^ k2 ^ k1 ^ k0 ^ t};
        bwd_key = {k0 ^ t, k1 ^ k0, k2 ^ k1, k3 ^ k2};
        rc_fwd  = {rc_q[6:0], 1'b0} ^ (rc_q[7] ? 8'h1b : 8'h00);
        rc_bwd  = rc_q[0] ? (((rc_q ^ 8'h1b) >> 1) | 8'h80) : (rc_q >> 1);
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        rc_d    = rc_q;
        busy_d  = busy_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    key_d   = key_in;
                    round_d = 4'd0;
                    rc_d    = 8'h01;
                    busy_d  = 1'b1;
                    state_d = StFwd;
                end
            end
            StFwd: begin
                key_d   = fwd_key;
                round_d = round_q + 4'd1;
                if (round_d == LastRound) begin
                    valid_d = 1'b1;
                    state_d = StEmit;
                end else begin
                    rc_d = rc_fwd;
                end
            end
            StEmit: begin
                if (kout_ready) begin
                    if (round_q != 4'd0) begin
                        key_d   = bwd_key;
                        round_d = round_q - 4'd1;
                        rc_d    = rc_bwd;
                    end else begin
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            key_q   <= '0;
            round_q <= 4'd0;
            rc_q    <= 8'h01;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            rc_q    <= rc_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    assign busy       = busy_q;
    assign kout       = key_q;
    assign kout_round = round_q;
    assign kout_valid = valid_q;
    assign done       = done_q;

endmodule

// AES forward S-box, table lookup.
module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    localparam logic [0:2047] SboxTable = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    always_comb begin
        out_o = SboxTable[{in_i, 3'b000} +: 8];
    end

endmodule

// File: tb/tb_aes_dec_key_sched.sv
// Scoreboard bench for aes_dec_key_sched: expected round keys are queued when a run starts
// and a negedge monitor pops and compares them on every kout handshake.

module tb_aes_dec_key_sched;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic [127:0] kout;
    logic [3:0]   kout_round;
    logic         kout_valid;
    logic         kout_ready;
    logic         done;

    int checks = 0;
    int errors = 0;

    logic [131:0] sb [$];
    int           ready_mode = 0;
    int           bp_hold = 0;
    logic         tog = 1'b0;
    int           done_seen = 0;
    logic         prev_done = 1'b0;
    logic         stall_prev = 1'b0;
    logic [127:0] held_k;
    logic [3:0]   held_r;

    aes_dec_key_sched #(.NR(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key_in     (key_in),
        .busy       (busy),
        .kout       (kout),
        .kout_round (kout_round),
        .kout_valid (kout_valid),
        .kout_ready (kout_ready),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Round keys 0..10 for FIPS-197, all-zero and all-ones cipher keys.
    function automatic logic [127:0] rk(input int set, input int r);
        logic [127:0] tbl [0:10];
        case (set)
            0: tbl = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
                       128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
                       128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
                       128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
                       128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
                       128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
            1: tbl = '{128'h00000000000000000000000000000000, 128'h62636363626363636263636362636363,
                       128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa, 128'h90973450696ccffaf2f457330b0fac99,
                       128'hee06da7b876a1581759e42b27e91ee2b, 128'h7f2e2b88f8443e098dda7cbbf34b9290,
                       128'hec614b851425758c99ff09376ab49ba7, 128'h217517873550620bacaf6b3cc61bf09b,
                       128'h0ef903333ba9613897060a04511dfa9f, 128'hb1d4d8e28a7db9da1d7bb3de4c664941,
                       128'hb4ef5bcb3e92e21123e951cf6f8f188e};
            default: tbl = '{128'hffffffffffffffffffffffffffffffff, 128'he8e9e9e917161616e8e9e9e917161616,
                       128'hadaeae19bab8b80f525151e6454747f0, 128'h090e2277b3b69a78e1e7cb9ea4a08c6e,
                       128'he16abd3e52dc2746b33becd8179b60b6, 128'he5baf3ceb766d488045d385013c658e6,
                       128'h71d07db3c6b6a93bc2eb916bd12dc98d, 128'he90d208d2fbb89b6ed5018dd3c7dd150,
                       128'h96337366b988fad054d8e20d68a5335d, 128'h8bf03f233278c5f366a027fe0e0514a3,
                       128'hd60a3588e472f07b82d2d7858cd7c326};
        endcase
        return tbl[r];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] tbl [0:10];
        tbl = '{8'h8d, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
        return tbl[r];
    endfunction

    // Ready driver: mode 0 always ready; mode 1 stalls 5 cycles at round 7 then toggles.
    always @(posedge clk) begin
        #1;
        if (ready_mode == 1) begin
            if (bp_hold < 5 && kout_valid && kout_round == 4'd7) begin
                kout_ready = 1'b0;
                bp_hold++;
            end else if (bp_hold >= 5) begin
                tog = ~tog;
                kout_ready = tog;
            end else begin
                kout_ready = 1'b1;
            end
        end else begin
            bp_hold = 0;
            tog = 1'b0;
            kout_ready = 1'b1;
        end
    end

    // Monitor: scoreboard pop on handshake, stability under stall, done pulse width.
    always @(negedge clk) begin
        if (!rst) begin
            if (kout_valid && stall_prev) begin
                chk("stall_key_stable", kout, held_k);
                chk("stall_round_stable", 128'(kout_round), 128'(held_r));
            end
            if (kout_valid && kout_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_key", 128'(kout_round), 128'hffff);
                end else begin
                    logic [131:0] e;
                    e = sb.pop_front();
                    chk("kout_round", 128'(kout_round), 128'(e[131:128]));
                    chk("kout_key", kout, e[127:0]);
                    if (e[131:128] != 4'd0)
                        chk("rc_backward", 128'(dut.rc_q), 128'(rcon(e[131:128])));
                end
            end
            if (done) begin
                done_seen++;
                chk("done_single_pulse", 128'(prev_done), 128'd0);
            end
            stall_prev = kout_valid && !kout_ready;
            held_k     = kout;
            held_r     = kout_round;
            prev_done  = done;
        end else begin
            stall_prev = 1'b0;
            prev_done  = 1'b0;
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle where done is visible.
    task automatic run(input int set, input int mode, input bit inject);
        int cnt;
        for (int r = 10; r >= 0; r--) sb.push_back({4'(r), rk(set, r)});
        ready_mode = mode;
        key_in = rk(set, 0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cnt = 0;
        while (!kout_valid && cnt < 40) begin
            @(posedge clk);
            #1;
            cnt++;
            start = inject && (cnt == 3);
        end
        chk("valid_latency", 128'(cnt), 128'd10);
        chk("busy_in_emit", 128'(busy), 128'd1);
        while (!done && cnt < 300) begin
            @(posedge clk);
            #1;
            cnt++;
            start = inject && ((cnt == 13) || (kout_valid && kout_round == 4'd0));
            if (start) key_in = ~key_in;
        end
        start = 1'b0;
        chk("done_seen", 128'(done), 128'd1);
        chk("busy_after_done", 128'(busy), 128'd0);
        chk("valid_after_done", 128'(kout_valid), 128'd0);
        if (mode == 0) chk("start_to_done", 128'(cnt), 128'd21);
        chk("scoreboard_drained", 128'(sb.size()), 128'd0);
        ready_mode = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        key_in = '0;
        kout_ready = 1'b1;
        #12;
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_valid", 128'(kout_valid), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_kout", kout, 128'd0);
        chk("rst_round", 128'(kout_round), 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset four cycles into the forward expansion.
        key_in = rk(0, 0);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("busy_mid_fwd", 128'(busy), 128'd1);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_valid", 128'(kout_valid), 128'd0);
        chk("midrst_kout", kout, 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        run(0, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        run(0, 1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        run(0, 0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        run(1, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        run(2, 0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        run(0, 0, 1'b0);
        run(0, 0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("idle_no_valid", 128'(kout_valid), 128'd0);
        chk("idle_not_busy", 128'(busy), 128'd0);
        chk("done_count", 128'(done_seen), 128'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
